// File: rtl/wmst_pkg.sv
// Shared constants, derivation helpers and state enums for the output feature-map
// write-master feeder.
package wmst_pkg;

  typedef enum logic {
    X_IDLE = 1'b0,
    X_RUN  = 1'b1
  } xfer_state_e;

  typedef enum logic {
    CIDLE = 1'b0,
    CWAIT = 1'b1
  } cmd_state_e;

  function automatic int wcnt_f(input int dw, input int xdw);
    return xdw / dw;
  endfunction

  function automatic int beat_bytes_f(input int xdw);
    return xdw / 8;
  endfunction

  function automatic int burst_beats_f(input int blen, input int wcnt);
    return blen / wcnt;
  endfunction

  function automatic logic [31:0] ceil_div_f(input logic [31:0] a, input logic [31:0] b);
    return (a + b - 32'd1) / b;
  endfunction

endpackage

// File: rtl/wmst_beat_packer.sv
// Packs FIFO words into write-master beats: lane assembly, zero-padding of the tail,
// the output beat register and the FIFO pop gating that keeps it from overrunning.
module wmst_beat_packer
  import wmst_pkg::*;
#(
  parameter int DW  = 32,
  parameter int XDW = 128,
  parameter int AW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run_i,
  input  logic           clr_i,
  input  logic [AW-1:0]  len_i,
  input  logic [DW-1:0]  fifo_data,
  input  logic           fifo_empty,
  input  logic           push_i,
  output logic           fifo_pop_o,
  output logic [XDW-1:0] beat_data_o,
  output logic           occupied_o
);

  localparam int WCNT = wcnt_f(DW, XDW);
  localparam int LW   = $clog2(WCNT);

  logic [AW-1:0]  popped_q, popped_d;
  logic           pend_q, pend_d;
  logic [LW-1:0]  pend_lane_q, pend_lane_d;
  logic           pend_last_q, pend_last_d;
  logic [XDW-1:0] asm_q, asm_d;
  logic [XDW-1:0] beat_q, beat_d;
  logic           occ_q, occ_d;

  logic           load_s, occ_next_s, pop_s, pop_last_s, pop_completes_s;
  logic [AW:0]    popped_inc_s;
  logic [XDW-1:0] asm_lane_s;

  // A word popped now lands next cycle; hold it back if it would finish a beat the register cannot take.
  always_comb begin
    load_s          = pend_q && ((pend_lane_q == LW'(WCNT - 1)) || pend_last_q);
    occ_next_s      = load_s || (occ_q && !push_i);
    popped_inc_s    = {1'b0, popped_q} + {{AW{1'b0}}, 1'b1};
    pop_last_s      = (popped_inc_s == {1'b0, len_i});
    pop_completes_s = (popped_q[LW-1:0] == LW'(WCNT - 1)) || pop_last_s;
    pop_s           = run_i && !fifo_empty && (popped_q < len_i) && !(pop_completes_s && occ_next_s);

    asm_lane_s = asm_q;
    for (int i = 0; i < WCNT; i++) begin
      if (pend_q && (pend_lane_q == LW'(i))) begin
        asm_lane_s[i*DW +: DW] = fifo_data;
      end else begin
        asm_lane_s[i*DW +: DW] = asm_q[i*DW +: DW];
      end
    end

    popped_d    = popped_q;
    pend_d      = pop_s;
    pend_lane_d = popped_q[LW-1:0];
    pend_last_d = pop_last_s;
    asm_d       = asm_q;
    beat_d      = beat_q;
    occ_d       = occ_q;
    if (clr_i) begin
      popped_d = '0;
      pend_d   = 1'b0;
      asm_d    = '0;
      occ_d    = 1'b0;
    end else begin
      if (pop_s) begin
        popped_d = popped_inc_s[AW-1:0];
      end else begin
        popped_d = popped_q;
      end
      // Assembly restarts from all-zero lanes, so a short final beat is padded for free.
      if (load_s) begin
        beat_d = asm_lane_s;
        asm_d  = '0;
        occ_d  = 1'b1;
      end else if (push_i) begin
        asm_d = asm_lane_s;
        occ_d = 1'b0;
      end else begin
        asm_d = asm_lane_s;
        occ_d = occ_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      popped_q    <= '0;
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
      pend_last_q <= 1'b0;
      asm_q       <= '0;
      beat_q      <= '0;
      occ_q       <= 1'b0;
    end else begin
      popped_q    <= popped_d;
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      pend_last_q <= pend_last_d;
      asm_q       <= asm_d;
      beat_q      <= beat_d;
      occ_q       <= occ_d;
    end
  end

  assign fifo_pop_o  = pop_s;
  assign beat_data_o = beat_q;
  assign occupied_o  = occ_q;

endmodule

// File: rtl/wmst_out_fm_packer.sv
// Store-FIFO to Avalon write-master feeder: transfer control, beat counters and burst
// command FSM. Define WMST_STALL_CNT_EN to add the stall_cycles output.
module wmst_out_fm_packer
  import wmst_pkg::*;
#(
  parameter int DW   = 32,
  parameter int XDW  = 128,
  parameter int XAW  = 32,
  parameter int AW   = 16,
  parameter int CW   = 16,
  parameter int BLEN = 8
) (
  input  logic           clk,
  input  logic           rst,
`ifdef WMST_STALL_CNT_EN
  output logic [31:0]    stall_cycles,
`endif
  input  logic           xfer_start,
  input  logic [XAW-1:0] xfer_base,
  input  logic [AW-1:0]  xfer_len,
  output logic           xfer_busy,
  output logic           xfer_done,
  input  logic [DW-1:0]  fifo_data,
  input  logic           fifo_empty,
  output logic           fifo_pop,
  output logic           wmst_fixed_location,
  output logic [XAW-1:0] wmst_write_base,
  output logic [CW-1:0]  wmst_write_length,
  output logic           wmst_go,
  input  logic           wmst_done,
  output logic [XDW-1:0] wmst_user_write_data,
  output logic           wmst_user_write_buffer,
  input  logic           wmst_user_buffer_full
);

  localparam int WCNT        = wcnt_f(DW, XDW);
  localparam int BEAT_BYTES  = beat_bytes_f(XDW);
  localparam int BURST_BEATS = burst_beats_f(BLEN, WCNT);
  localparam int BB_SH       = $clog2(BEAT_BYTES);

  xfer_state_e    xst_q, xst_d;
  cmd_state_e     cst_q, cst_d;
  logic [XAW-1:0] base_q, base_d;
  logic [AW-1:0]  len_q, len_d;
  logic [AW-1:0]  beats_q, beats_d;
  logic [AW-1:0]  pushed_q, pushed_d;
  logic [AW-1:0]  issued_q, issued_d;
  logic           done_q, done_d;
  logic           go_q, go_d;
  logic [XAW-1:0] wbase_q, wbase_d;
  logic [CW-1:0]  wlen_q, wlen_d;
  logic [1:0]     ign_q, ign_d;
  logic           low_q, low_d;

  logic           start_s, push_s, occ_s, go_s;
  logic [AW-1:0]  avail_s, nb_s;

  wmst_beat_packer #(.DW(DW), .XDW(XDW), .AW(AW)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .run_i       (xst_q == X_RUN),
    .clr_i       (start_s),
    .len_i       (len_q),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .push_i      (push_s),
    .fifo_pop_o  (fifo_pop),
    .beat_data_o (wmst_user_write_data),
    .occupied_o  (occ_s)
  );

  // Transfer and command next-state; the go decision uses counts before this cycle's push.
  always_comb begin
    push_s  = occ_s && !wmst_user_buffer_full;
    start_s = xfer_start && (xst_q == X_IDLE) && !done_q;
    avail_s = pushed_q - issued_q;
    nb_s    = (avail_s >= AW'(BURST_BEATS)) ? AW'(BURST_BEATS) : avail_s;
    go_s    = (xst_q == X_RUN) && (cst_q == CIDLE) && wmst_done &&
              ((avail_s >= AW'(BURST_BEATS)) || ((pushed_q == beats_q) && (pushed_q != issued_q)));

    xst_d    = xst_q;
    cst_d    = cst_q;
    base_d   = base_q;
    len_d    = len_q;
    beats_d  = beats_q;
    pushed_d = pushed_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    go_d     = 1'b0;
    wbase_d  = wbase_q;
    wlen_d   = wlen_q;
    ign_d    = ign_q;
    low_d    = low_q;

    case (xst_q)
      X_IDLE: begin
        if (start_s) begin
          base_d   = xfer_base;
          len_d    = xfer_len;
          beats_d  = AW'(ceil_div_f(32'(xfer_len), 32'(WCNT)));
          pushed_d = '0;
          issued_d = '0;
          cst_d    = CIDLE;
          if (xfer_len == '0) begin
            done_d = 1'b1;
          end else begin
            xst_d = X_RUN;
          end
        end else begin
          xst_d = X_IDLE;
        end
      end
      X_RUN: begin
        if (push_s) begin
          pushed_d = pushed_q + AW'(1);
        end else begin
          pushed_d = pushed_q;
        end
        case (cst_q)
          CIDLE: begin
            if (go_s) begin
              go_d     = 1'b1;
              wbase_d  = base_q + (XAW'(issued_q) << BB_SH);
              wlen_d   = CW'(nb_s) << BB_SH;
              issued_d = issued_q + nb_s;
              ign_d    = 2'd2;
              low_d    = 1'b0;
              cst_d    = CWAIT;
            end else begin
              cst_d = CIDLE;
            end
          end
          CWAIT: begin
            // Skip the go cycle and the one after, then require done low before accepting high.
            if (ign_q != 2'd0) begin
              ign_d = ign_q - 2'd1;
            end else if (!wmst_done) begin
              low_d = 1'b1;
            end else if (low_q) begin
              cst_d = CIDLE;
              if (issued_q == beats_q) begin
                done_d = 1'b1;
                xst_d  = X_IDLE;
              end else begin
                xst_d = X_RUN;
              end
            end else begin
              cst_d = CWAIT;
            end
          end
          default: cst_d = CIDLE;
        endcase
      end
      default: xst_d = X_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xst_q    <= X_IDLE;
      cst_q    <= CIDLE;
      base_q   <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      pushed_q <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
      go_q     <= 1'b0;
      wbase_q  <= '0;
      wlen_q   <= '0;
      ign_q    <= 2'd0;
      low_q    <= 1'b0;
    end else begin
      xst_q    <= xst_d;
      cst_q    <= cst_d;
      base_q   <= base_d;
      len_q    <= len_d;
      beats_q  <= beats_d;
      pushed_q <= pushed_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      go_q     <= go_d;
      wbase_q  <= wbase_d;
      wlen_q   <= wlen_d;
      ign_q    <= ign_d;
      low_q    <= low_d;
    end
  end

`ifdef WMST_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles a ready beat is held back by a full write-master buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (start_s) begin
      stall_q <= 32'd0;
    end else if (occ_s && wmst_user_buffer_full && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign xfer_busy              = (xst_q == X_RUN);
  assign xfer_done              = done_q;
  assign wmst_go                = go_q;
  assign wmst_write_base        = wbase_q;
  assign wmst_write_length      = wlen_q;
  assign wmst_fixed_location    = 1'b0;
  assign wmst_user_write_buffer = push_s;

endmodule

// File: tb/tb_wmst_out_fm_packer.sv
// Directed bench for wmst_out_fm_packer: vector table of transfers plus hand-written
// length-zero, ignored-start, stall and mid-transfer reset sequences.
module tb_wmst_out_fm_packer;

  localparam int DW = 32, XDW = 128, XAW = 32, AW = 16, CW = 16, BLEN = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           xfer_start = 1'b0;
  logic [XAW-1:0] xfer_base = '0;
  logic [AW-1:0]  xfer_len = '0;
  logic           xfer_busy, xfer_done;
  logic [DW-1:0]  fifo_data = '0;
  logic           fifo_empty, fifo_pop;
  logic           wmst_fixed_location, wmst_go, wmst_done;
  logic [XAW-1:0] wmst_write_base;
  logic [CW-1:0]  wmst_write_length;
  logic [XDW-1:0] wmst_user_write_data;
  logic           wmst_user_write_buffer;
  logic           wmst_user_buffer_full = 1'b0;
`ifdef WMST_STALL_CNT_EN
  logic [31:0]    stall_cycles;
`endif

  wmst_out_fm_packer #(.DW(DW), .XDW(XDW), .XAW(XAW), .AW(AW), .CW(CW), .BLEN(BLEN)) dut (
    .clk                    (clk),
    .rst                    (rst),
`ifdef WMST_STALL_CNT_EN
    .stall_cycles           (stall_cycles),
`endif
    .xfer_start             (xfer_start),
    .xfer_base              (xfer_base),
    .xfer_len               (xfer_len),
    .xfer_busy              (xfer_busy),
    .xfer_done              (xfer_done),
    .fifo_data              (fifo_data),
    .fifo_empty             (fifo_empty),
    .fifo_pop               (fifo_pop),
    .wmst_fixed_location    (wmst_fixed_location),
    .wmst_write_base        (wmst_write_base),
    .wmst_write_length      (wmst_write_length),
    .wmst_go                (wmst_go),
    .wmst_done              (wmst_done),
    .wmst_user_write_data   (wmst_user_write_data),
    .wmst_user_write_buffer (wmst_user_write_buffer),
    .wmst_user_buffer_full  (wmst_user_buffer_full)
  );

  always #5 clk = ~clk;

  // FIFO model, write-master model and monitors.
  logic [31:0]  mem [0:63];
  int           n_words = 0;
  int           rd_ptr = 0;
  logic         clr_mon = 1'b0;
  logic         tog_en = 1'b0;
  logic         empty_force = 1'b0;
  int           wcnt = 0;
  logic [127:0] beats_m [0:63];
  logic [31:0]  gbase [0:15];
  logic [15:0]  glen [0:15];
  int           nbeats = 0, ngo = 0, ndone = 0, npop = 0, nbadpop = 0;

  assign fifo_empty = empty_force || (rd_ptr >= n_words);
  assign wmst_done  = (wcnt == 0);

  always @(posedge clk) begin
    if (tog_en) empty_force <= ~empty_force;
    else        empty_force <= 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)          wcnt <= 0;
    else if (wmst_go) wcnt <= 6;
    else if (wcnt > 0) wcnt <= wcnt - 1;
  end

  always @(posedge clk) begin
    if (clr_mon) begin
      rd_ptr <= 0; nbeats <= 0; ngo <= 0; ndone <= 0; npop <= 0; nbadpop <= 0;
    end else begin
      if (fifo_pop) begin
        if (rd_ptr < 64) fifo_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
        npop   <= npop + 1;
        if (fifo_empty) nbadpop <= nbadpop + 1;
      end
      if (wmst_user_write_buffer && !wmst_user_buffer_full) begin
        if (nbeats < 64) beats_m[nbeats] <= wmst_user_write_data;
        nbeats <= nbeats + 1;
      end
      if (wmst_go) begin
        if (ngo < 16) begin
          gbase[ngo] <= wmst_write_base;
          glen[ngo]  <= wmst_write_length;
        end
        ngo <= ngo + 1;
      end
      if (xfer_done) ndone <= ndone + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int len;
    bit dup;
    bit tog;
    bit stall;
    int exp_beats;
    int exp_gos;
    int exp_last_len;
  } vec_t;

  vec_t vecs [0:6];

  task automatic load_fifo(input int tag, input int len);
    for (int k = 0; k < 64; k++) mem[k] = (k < len) ? ((tag << 16) | (k + 1)) : 32'd0;
    n_words = len;
    clr_mon = 1'b1;
    @(negedge clk);
    clr_mon = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input int len);
    xfer_base  = base;
    xfer_len   = AW'(len);
    xfer_start = 1'b1;
    @(negedge clk);
    xfer_start = 1'b0;
  endtask

  task automatic run_vec(input int v);
    vec_t         t;
    int           cyc;
    int           w;
    logic [127:0] exp;
    t = vecs[v];
    load_fifo(v, t.len);
    tog_en = t.tog;
    pulse_start(32'h1000, t.len);
    if (t.dup) begin
      repeat (5) @(negedge clk);
      pulse_start(32'h2000, 4);
    end
    if (t.stall) begin
      cyc = 0;
      while (!wmst_user_write_buffer && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("stall_wait_timeout", (cyc >= 200) ? 1 : 0, 0);
      wmst_user_buffer_full = 1'b1;
      repeat (5) @(negedge clk);
      chk("stall_pop_held", fifo_pop, 0);
      @(negedge clk);
      wmst_user_buffer_full = 1'b0;
    end
    cyc = 0;
    while (ndone == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_done_timeout", v), (cyc >= 3000) ? 1 : 0, 0);
    repeat (10) @(negedge clk);
    tog_en = 1'b0;
    chk($sformatf("v%0d_done_count", v), ndone, 1);
    chk($sformatf("v%0d_busy_after", v), xfer_busy, 0);
    chk($sformatf("v%0d_beats", v), nbeats, t.exp_beats);
    chk($sformatf("v%0d_gos", v), ngo, t.exp_gos);
    chk($sformatf("v%0d_pops", v), npop, t.len);
    chk($sformatf("v%0d_pop_empty", v), nbadpop, 0);
    for (int b = 0; b < t.exp_beats && b < nbeats; b++) begin
      exp = '0;
      for (int l = 0; l < 4; l++) begin
        w = b * 4 + l;
        if (w < t.len) exp[l*32 +: 32] = mem[w];
      end
      chk128($sformatf("v%0d_beat%0d", v, b), beats_m[b], exp);
    end
    for (int g = 0; g < t.exp_gos && g < ngo; g++) begin
      chk($sformatf("v%0d_go%0d_base", v, g), gbase[g], 32'h1000 + g * 32);
      chk($sformatf("v%0d_go%0d_len", v, g), glen[g], (g == t.exp_gos - 1) ? t.exp_last_len : 32);
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{10, 1'b0, 1'b0, 1'b0, 3, 2, 16};
    vecs[1] = '{32, 1'b1, 1'b0, 1'b0, 8, 4, 32};
    vecs[2] = '{16, 1'b0, 1'b1, 1'b0, 4, 2, 32};
    vecs[3] = '{12, 1'b0, 1'b0, 1'b1, 3, 2, 16};
    vecs[4] = '{5,  1'b0, 1'b0, 1'b0, 2, 1, 32};
    vecs[5] = '{1,  1'b0, 1'b0, 1'b0, 1, 1, 16};
    vecs[6] = '{8,  1'b0, 1'b0, 1'b0, 2, 1, 32};
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", xfer_busy, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_go", wmst_go, 0);
    chk("rst_wbuf", wmst_user_write_buffer, 0);
    chk("rst_fixed", wmst_fixed_location, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_pop", fifo_pop, 0);

    for (int v = 0; v < 6; v++) begin
      run_vec(v);
      if (v == 0) chk128("len10_beat2", beats_m[2], {32'd0, 32'd0, 32'd10, 32'd9});
`ifdef WMST_STALL_CNT_EN
      if (v == 3) chk("stall_cycles", stall_cycles, 6);
`endif
    end

    // Zero-length transfer: done the next cycle, nothing else moves.
    load_fifo(9, 4);
    pulse_start(32'h1000, 0);
    chk("len0_done_pulse", xfer_done, 1);
    chk("len0_busy", xfer_busy, 0);
    @(negedge clk);
    chk("len0_done_single", xfer_done, 0);
    repeat (10) @(negedge clk);
    chk("len0_gos", ngo, 0);
    chk("len0_pops", npop, 0);

    // Reset in the middle of the second burst.
    load_fifo(7, 32);
    pulse_start(32'h1000, 32);
    cyc = 0;
    while (ngo < 2 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_wait_timeout", (cyc >= 1000) ? 1 : 0, 0);
    rst = 1'b1;
    #1;
    chk("rstmid_go", wmst_go, 0);
    chk("rstmid_pop", fifo_pop, 0);
    chk("rstmid_busy", xfer_busy, 0);
    chk("rstmid_wbuf", wmst_user_write_buffer, 0);
    chk("rstmid_wbase", wmst_write_base, 0);
    chk("rstmid_wlen", wmst_write_length, 0);
    chk("rstmid_data", (wmst_user_write_data == '0) ? 1 : 0, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
